inv: RTL and testbench
======================

Name: inv

Overview:
- Registered full subtractor with a ripple-borrow chain.
- Computes the difference x - y - b0 and a borrow-out, captured into output registers on the clock edge.
- Used as a leaf arithmetic block; WIDTH=1 gives the classic 1-bit full subtractor (inputs x, y, b0; outputs d, b).
- Wider instances form an N-bit subtractor, and a borrow output can chain to the next stage's b0.

Parameters:
- WIDTH, 1, operand and difference width in bits (legal range 1..64).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  qualifies x, y, b0 for capture this cycle.
- x  input  WIDTH  minuend.
- y  input  WIDTH  subtrahend.
- b0  input  1  borrow-in (1 = subtract an extra 1).
- d  output  WIDTH  registered difference.
- b  output  1  registered borrow-out.
- out_valid  output  1  d/b hold a result captured on the previous in_valid cycle.

Behaviour:
- Reset: while rst_n=0, d=0, b=0, out_valid=0 immediately (asynchronous assert); release is synchronous to the next clk edge.
- Arithmetic: {b, d} = ({1'b0,x} - {1'b0,y} - b0) mod 2^(WIDTH+1).
  - b=1 exactly when x < y + b0 (unsigned).
  - d is the low WIDTH bits of the difference.
- Per-bit equations, bit i, with borrow c[0]=b0:
  - d[i] = x[i] ^ y[i] ^ c[i].
  - c[i+1] = (~x[i] & y[i]) | (~x[i] & c[i]) | (y[i] & c[i]).
  - b = c[WIDTH].
- Implementation is an explicit ripple-borrow chain of 1-bit full-subtractor slices (generate loop). Using a behavioural "-" operator is not permitted.
- Latency: 1 cycle. Sample on rising clk edge when in_valid=1; the result appears on d/b with out_valid=1 after that edge.
- in_valid=0 at an edge:
  - d and b hold their previous values.
  - out_valid drops to 0.
- Back-to-back in_valid=1: one result per cycle, no bubbles, no backpressure.
- Inputs are combinationally consumed only at the clock edge. Input changes between edges have no effect on outputs.
- WIDTH=1 truth table (x y b0 -> d b):
  - 000->00, 001->11, 010->11, 011->01
  - 100->10, 101->00, 110->00, 111->11
- Wrap-around: x=0, y=2^WIDTH-1, b0=1 -> d=0, b=1.
- Reset mid-operation: in-flight result is discarded; out_valid=0 until a new in_valid capture after reset release.
- X/Z on inputs with in_valid=0 must not corrupt held outputs.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with outputs nonzero -> d=0, b=0, out_valid=0 immediately, without waiting for a clock edge.
- WIDTH=1 exhaustive: drive all 8 (x,y,b0) combinations, one per cycle, in_valid=1 -> each result matches the truth table one cycle later with out_valid=1; e.g. 011 -> d=0, b=1; 100 -> d=1, b=0.
- WIDTH=8: x=8'h05, y=8'h03, b0=0 -> d=8'h02, b=0. Then x=8'h03, y=8'h05, b0=0 -> d=8'hFE, b=1.
- Wrap boundary, WIDTH=8: x=8'h00, y=8'hFF, b0=1 -> d=8'h00, b=1. Then x=8'hFF, y=8'h00, b0=1 -> d=8'hFE, b=0.
- Hold: capture x=8'h10, y=8'h01, b0=0 (d=8'h0F), then 3 cycles of in_valid=0 with random x/y -> d stays 8'h0F, b stays 0, out_valid=0.
- Random WIDTH=16: 1000 back-to-back in_valid=1 vectors -> every {b,d} equals the reference model ({1'b0,x} - {1'b0,y} - b0) mod 2^17, checked one cycle later.

Source files
------------

// File: rtl/inv.sv
// Registered full subtractor: {b, d} = x - y - b0, built from a ripple-borrow
// chain of 1-bit full-subtractor slices with a one-cycle registered output.
module inv #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             b0,
    output logic [WIDTH-1:0] d,
    output logic             b,
    output logic             out_valid
);

    logic [WIDTH:0]   borrow_s;
    logic [WIDTH-1:0] diff_s;

    logic [WIDTH-1:0] d_q, d_d;
    logic             b_q, b_d;
    logic             valid_q, valid_d;

    assign borrow_s[0] = b0;

    // Borrow into slice i+1 is raised when slice i cannot cover y[i] plus its incoming borrow.
    for (genvar i = 0; i < WIDTH; i++) begin : g_slice
        assign diff_s[i]       = x[i] ^ y[i] ^ borrow_s[i];
        assign borrow_s[i+1]   = (~x[i] & y[i]) | (~x[i] & borrow_s[i]) | (y[i] & borrow_s[i]);
    end

    // Next-state selection: capture a new result on in_valid, otherwise hold d/b and drop valid.
    always_comb begin
        d_d     = d_q;
        b_d     = b_q;
        valid_d = 1'b0;
        if (in_valid == 1'b1) begin
            d_d     = diff_s;
            b_d     = borrow_s[WIDTH];
            valid_d = 1'b1;
        end else begin
            d_d     = d_q;
            b_d     = b_q;
            valid_d = 1'b0;
        end
    end

    // Output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q     <= '0;
            b_q     <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            d_q     <= d_d;
            b_q     <= b_d;
            valid_q <= valid_d;
        end
    end

    assign d         = d_q;
    assign b         = b_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_inv.sv
// Self-checking bench for inv at WIDTH=1, 8 and 16 against a plain-arithmetic
// reference model and the 1-bit truth table.
module tb_inv;

    logic clk;
    logic rst_n;

    logic        v1, x1, y1, bi1, d1, bo1, ov1;
    logic        v8, bi8, bo8, ov8;
    logic [7:0]  x8, y8, d8;
    logic        v16, bi16, bo16, ov16;
    logic [15:0] x16, y16, d16;

    int pass_cnt;
    int total_cnt;

    inv #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .x(x1), .y(y1), .b0(bi1),
        .d(d1), .b(bo1), .out_valid(ov1)
    );

    inv #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8), .x(x8), .y(y8), .b0(bi8),
        .d(d8), .b(bo8), .out_valid(ov8)
    );

    inv #(.WIDTH(16)) u_w16 (
        .clk(clk), .rst_n(rst_n), .in_valid(v16), .x(x16), .y(y16), .b0(bi16),
        .d(d16), .b(bo16), .out_valid(ov16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: unsigned (WIDTH+1)-bit difference, borrow is the top bit.
    function automatic logic [8:0] ref8(input logic [7:0] a, input logic [7:0] s, input logic bi);
        int r;
        r = int'(a) - int'(s) - int'(bi);
        if (r < 0) r = r + 512;
        return 9'(r);
    endfunction

    function automatic logic [16:0] ref16(input logic [15:0] a, input logic [15:0] s, input logic bi);
        int r;
        r = int'(a) - int'(s) - int'(bi);
        if (r < 0) r = r + 131072;
        return 17'(r);
    endfunction

    task automatic drive8(input logic [7:0] a, input logic [7:0] s, input logic bi);
        @(negedge clk);
        v8 = 1'b1; x8 = a; y8 = s; bi8 = bi;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_initial();
        #1;
        total_cnt++;
        if ({d1, bo1, ov1, d8, bo8, ov8, d16, bo16, ov16} !== '0) begin
            $display("FAIL reset_initial: got d1=%b b1=%b ov1=%b d8=%h b8=%b ov8=%b d16=%h b16=%b ov16=%b, want all 0",
                     d1, bo1, ov1, d8, bo8, ov8, d16, bo16, ov16);
        end else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_truth_table_w1();
        logic [1:0] tt [8];
        logic [2:0] idx;
        tt = '{2'b00, 2'b11, 2'b11, 2'b01, 2'b10, 2'b00, 2'b00, 2'b11};
        for (int k = 0; k < 8; k++) begin
            idx = 3'(k);
            @(negedge clk);
            v1 = 1'b1; x1 = idx[2]; y1 = idx[1]; bi1 = idx[0];
            @(posedge clk);
            #1;
            total_cnt++;
            if ({d1, bo1, ov1} !== {tt[k], 1'b1}) begin
                $display("FAIL truth_w1 xyb0=%b: got d=%b b=%b ov=%b, want d=%b b=%b ov=1",
                         idx, d1, bo1, ov1, tt[k][1], tt[k][0]);
            end else pass_cnt++;
        end
        @(negedge clk);
        v1 = 1'b0;
    endtask

    task automatic test_basic_w8();
        logic [7:0] xs [4];
        logic [7:0] ys [4];
        logic       bs [4];
        logic [8:0] want [4];
        xs = '{8'h05, 8'h03, 8'h00, 8'hFF};
        ys = '{8'h03, 8'h05, 8'hFF, 8'h00};
        bs = '{1'b0, 1'b0, 1'b1, 1'b1};
        want = '{{1'b0, 8'h02}, {1'b1, 8'hFE}, {1'b1, 8'h00}, {1'b0, 8'hFE}};
        for (int k = 0; k < 4; k++) begin
            drive8(xs[k], ys[k], bs[k]);
            total_cnt++;
            if ({bo8, d8, ov8} !== {want[k], 1'b1}) begin
                $display("FAIL basic_w8[%0d] %h-%h-%b: got b=%b d=%h ov=%b, want b=%b d=%h ov=1",
                         k, xs[k], ys[k], bs[k], bo8, d8, ov8, want[k][8], want[k][7:0]);
            end else pass_cnt++;
        end
    endtask

    task automatic test_hold_w8();
        drive8(8'h10, 8'h01, 1'b0);
        total_cnt++;
        if ({bo8, d8, ov8} !== {1'b0, 8'h0F, 1'b1}) begin
            $display("FAIL hold_capture: got b=%b d=%h ov=%b, want b=0 d=0f ov=1", bo8, d8, ov8);
        end else pass_cnt++;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            v8 = 1'b0;
            if (k == 3) begin
                x8 = 'x; y8 = 'x; bi8 = 1'bx;
            end else begin
                x8 = 8'($urandom); y8 = 8'($urandom); bi8 = 1'($urandom);
            end
            @(posedge clk);
            #1;
            total_cnt++;
            if ({bo8, d8, ov8} !== {1'b0, 8'h0F, 1'b0}) begin
                $display("FAIL hold_idle[%0d]: got b=%b d=%h ov=%b, want b=0 d=0f ov=0", k, bo8, d8, ov8);
            end else pass_cnt++;
        end
    endtask

    task automatic test_reset_midop();
        drive8(8'h03, 8'h05, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({bo8, d8, ov8} !== {1'b0, 8'h00, 1'b0}) begin
            $display("FAIL reset_async: got b=%b d=%h ov=%b, want b=0 d=00 ov=0", bo8, d8, ov8);
        end else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        v8 = 1'b0;
        @(posedge clk);
        #1;
        total_cnt++;
        if ({bo8, d8, ov8} !== {1'b0, 8'h00, 1'b0}) begin
            $display("FAIL reset_release: got b=%b d=%h ov=%b, want b=0 d=00 ov=0", bo8, d8, ov8);
        end else pass_cnt++;
    endtask

    task automatic test_back_to_back_w16();
        logic [16:0] want;
        int errs;
        errs = 0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            v16 = 1'b1;
            x16 = 16'($urandom); y16 = 16'($urandom); bi16 = 1'($urandom);
            if (k == 0) begin
                x16 = 16'h0000; y16 = 16'hFFFF; bi16 = 1'b1;
            end
            want = ref16(x16, y16, bi16);
            @(posedge clk);
            #1;
            total_cnt++;
            if ({bo16, d16, ov16} !== {want, 1'b1}) begin
                errs++;
                if (errs <= 10)
                    $display("FAIL rand_w16[%0d] %h-%h-%b: got b=%b d=%h ov=%b, want b=%b d=%h ov=1",
                             k, x16, y16, bi16, bo16, d16, ov16, want[16], want[15:0]);
            end else pass_cnt++;
        end
        @(negedge clk);
        v16 = 1'b0;
        @(posedge clk);
        #1;
        total_cnt++;
        if (ov16 !== 1'b0) begin
            $display("FAIL rand_w16_drop: got ov=%b, want ov=0", ov16);
        end else pass_cnt++;
    endtask

    task automatic test_random_w8();
        logic [7:0] a, s;
        logic bi;
        logic [8:0] want;
        for (int k = 0; k < 20; k++) begin
            a = 8'($urandom); s = 8'($urandom); bi = 1'($urandom);
            want = ref8(a, s, bi);
            drive8(a, s, bi);
            total_cnt++;
            if ({bo8, d8, ov8} !== {want, 1'b1}) begin
                $display("FAIL rand_w8[%0d] %h-%h-%b: got b=%b d=%h, want b=%b d=%h",
                         k, a, s, bi, bo8, d8, want[8], want[7:0]);
            end else pass_cnt++;
        end
        @(negedge clk);
        v8 = 1'b0;
    endtask

    initial begin
        pass_cnt = 0;
        total_cnt = 0;
        rst_n = 1'b0;
        v1 = 1'b0; x1 = 1'b0; y1 = 1'b0; bi1 = 1'b0;
        v8 = 1'b0; x8 = 8'h00; y8 = 8'h00; bi8 = 1'b0;
        v16 = 1'b0; x16 = 16'h0000; y16 = 16'h0000; bi16 = 1'b0;

        test_reset_initial();
        test_truth_table_w1();
        test_basic_w8();
        test_hold_w8();
        test_reset_midop();
        test_random_w8();
        test_back_to_back_w16();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
